mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 1024, data memory words (power of 2).
REQ-003 SHALL have parameter LOAD_LAT, default 1, load latency in cycles (legal 1..4).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-005 SHALL have inputs: RegWriteM 1, MemWriteM 1, MemReadM 1, ResultSrcM 1, Funct3M 3 (access size/sign), RD_M 5, PCPlus4M XLEN, WriteDataM XLEN, ALU_ResultM XLEN (address), FlushW 1 (bubble W register).
REQ-006 SHALL have outputs: RegWriteW 1, ResultSrcW 1, RD_W 5, PCPlus4W XLEN, ALU_ResultW XLEN, ReadDataW XLEN, StallM 1 (hold M inputs), MisalignW 1 (misaligned access flag).

Function
REQ-007 SHALL index memory by ALU_ResultM[log2(DEPTH)+1:2]; higher address bits ignored (wrap modulo DEPTH).
REQ-008 SHALL write on clk rising edge when MemWriteM=1 and StallM=0, byte enables per Funct3M: 000 SB lane ALU_ResultM[1:0]; 001 SH lanes {addr[1],0}..+1; 010 SW all four; other codes no write.
REQ-009 SHALL return loads per Funct3M: 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext, other codes return 0; lane chosen by ALU_ResultM[1:0].
REQ-010 SHALL implement FSM IDLE/BUSY plus down-counter width 2.
REQ-011 LOAD_LAT=1: no BUSY state; load data registered into ReadDataW at the edge ending the accept cycle; StallM constant 0.
REQ-012 LOAD_LAT>1: IDLE with MemReadM=1 -> BUSY, counter=LOAD_LAT-2; BUSY decrements each cycle; BUSY with counter=0 -> IDLE, W register captures load result at that edge.
REQ-013 StallM SHALL be 1 in IDLE when MemReadM=1 and LOAD_LAT>1, and in BUSY while counter!=0; 0 otherwise; total stall = LOAD_LAT-1 cycles per load.
REQ-014 While StallM=1 the W register SHALL load a bubble: RegWriteW=0, MisalignW=0, other W outputs hold.
REQ-015 When StallM=0 the W register SHALL capture RegWriteM, ResultSrcM, RD_M, PCPlus4M, ALU_ResultM, load data.
REQ-016 FlushW=1 SHALL force RegWriteW=0 and MisalignW=0 next edge, priority over REQ-014/015; store in M still commits; an in-flight load FSM proceeds unchanged.
REQ-017 MemWriteM and MemReadM both 1 SHALL be treated as a store only (no stall, no load).

Reset
REQ-018 rst=1 SHALL immediately set FSM IDLE, counter 0, StallM 0, and all W outputs 0 (RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW).
REQ-019 rst asserted mid-load SHALL abort the load with no W capture; memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-020 Macro MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL suppress the store, suppress stall, set RegWriteW=0 and MisalignW=1 for exactly one cycle.
REQ-021 Macro undefined: MisalignW tied 0; misaligned halfword/word addresses SHALL be aligned down (low bits cleared) and access proceeds normally.

Verification
REQ-022 LOAD_LAT=1: SW 0xDEADBEEF @0x10, then LB @0x13 -> ReadDataW=0xFFFFFFDE, LBU @0x13 -> 0x000000DE, one cycle after each.
REQ-023 SH 0x1234 @0x22 over word 0 -> LW @0x20 returns 0x12340000; LHU @0x22 returns 0x00001234.
REQ-024 LOAD_LAT=3: LW @0x10 -> StallM=1 for 2 cycles, RegWriteW=0 during stall, ReadDataW=0xDEADBEEF with RegWriteW=1 on third edge.
REQ-025 LOAD_LAT=3: rst pulsed in BUSY -> StallM=0, all W outputs 0 immediately; subsequent LW @0x10 still returns 0xDEADBEEF.
REQ-026 MEM_MISALIGN_TRAP_EN defined: SW 0xAAAAAAAA @0x11 -> MisalignW=1 one cycle, RegWriteW=0, word @0x10 unchanged; undefined build: same store writes word @0x10.
REQ-027 FlushW=1 with SW in M and RegWriteM=1 -> RegWriteW=0 next cycle, store data visible on later LW.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: byte-lane data memory, multi-cycle load sequencer and M->W pipeline register.
// Optional build macro MEM_MISALIGN_TRAP_EN: flag misaligned halfword/word accesses instead of aligning them down.
module mem_stage_lsu #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 1024,
   parameter int LOAD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic            MemReadM,
   input  logic            ResultSrcM,
   input  logic [2:0]      Funct3M,
   input  logic [4:0]      RD_M,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] ALU_ResultM,
   input  logic            FlushW,
   output logic            RegWriteW,
   output logic            ResultSrcW,
   output logic [4:0]      RD_W,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [XLEN-1:0] ALU_ResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic            StallM,
   output logic            MisalignW
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_BUSY   = 1'b1;
   localparam logic       MULTI    = 1'(LOAD_LAT > 1);
   localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

   logic [31:0]      mem_r [DEPTH];
   logic [AW-1:0]    idx_s;
   logic [1:0]       lane_s;
   logic [31:0]      word_s;
   logic [3:0]       be_s;
   logic [31:0]      wdata_s;
   logic             misalign_s;
   logic             load_req_s;
   logic             store_en_s;
   logic             stall_s;
   logic [XLEN-1:0]  load_data_s;
   logic [0:0]       state_r, state_nxt_s;
   logic [1:0]       cnt_r, cnt_nxt_s;

   logic             reg_write_w_r;
   logic             result_src_w_r;
   logic [4:0]       rd_w_r;
   logic [XLEN-1:0]  pc_plus4_w_r;
   logic [XLEN-1:0]  alu_result_w_r;
   logic [XLEN-1:0]  read_data_w_r;
   logic             misalign_w_r;

   // Lane extraction with sign/zero extension; halfword lane uses addr[1] only, so odd addresses align down.
   function automatic logic [XLEN-1:0] load_extract(input logic [31:0] word,
                                                    input logic [2:0]  f3,
                                                    input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {lane, 3'b000});
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
         3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
         3'b010:  load_extract = XLEN'(word);
         3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
         3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
         default: load_extract = {XLEN{1'b0}};
      endcase
   endfunction

   assign idx_s       = ALU_ResultM[AW+1:2];
   assign lane_s      = ALU_ResultM[1:0];
   assign word_s      = mem_r[idx_s];
   assign load_data_s = load_extract(word_s, Funct3M, lane_s);
   assign load_req_s  = MemReadM & ~MemWriteM & ~misalign_s;
   assign store_en_s  = MemWriteM & ~stall_s & ~misalign_s;

`ifdef MEM_MISALIGN_TRAP_EN
   // Misalignment detection for halfword/word accesses
   always_comb begin
      misalign_s = 1'b0;
      if (MemWriteM) begin
         case (Funct3M)
            3'b001:  misalign_s = lane_s[0];
            3'b010:  misalign_s = |lane_s;
            default: misalign_s = 1'b0;
         endcase
      end else if (MemReadM) begin
         case (Funct3M)
            3'b001, 3'b101: misalign_s = lane_s[0];
            3'b010:         misalign_s = |lane_s;
            default:        misalign_s = 1'b0;
         endcase
      end else begin
         misalign_s = 1'b0;
      end
   end
`else
   assign misalign_s = 1'b0;
`endif

   // Store byte enables and lane-replicated write data
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = WriteDataM[31:0];
      case (Funct3M)
         3'b000: begin
            be_s    = 4'b0001 << lane_s;
            wdata_s = {4{WriteDataM[7:0]}};
         end
         3'b001: begin
            be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{WriteDataM[15:0]}};
         end
         3'b010:  be_s = 4'b1111;
         default: be_s = 4'b0000;
      endcase
   end

   // Data array write port; contents survive reset
   always_ff @(posedge clk) begin
      if (store_en_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
         end
      end
   end

   // Load sequencer next state and stall generation
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      stall_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (MULTI && load_req_s) begin
               state_nxt_s = S_BUSY;
               cnt_nxt_s   = CNT_INIT;
               stall_s     = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_BUSY: begin
            if (cnt_r != 2'd0) begin
               cnt_nxt_s = cnt_r - 2'd1;
               stall_s   = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = 2'd0;
         end
      endcase
   end

   // Load sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         cnt_r   <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // M->W pipeline register: bubble while stalled, flush only kills the write-back and trap flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_w_r  <= 1'b0;
         result_src_w_r <= 1'b0;
         rd_w_r         <= 5'd0;
         pc_plus4_w_r   <= {XLEN{1'b0}};
         alu_result_w_r <= {XLEN{1'b0}};
         read_data_w_r  <= {XLEN{1'b0}};
         misalign_w_r   <= 1'b0;
      end else begin
         if (stall_s) begin
            reg_write_w_r <= 1'b0;
            misalign_w_r  <= 1'b0;
         end else begin
            reg_write_w_r  <= RegWriteM & ~misalign_s;
            result_src_w_r <= ResultSrcM;
            rd_w_r         <= RD_M;
            pc_plus4_w_r   <= PCPlus4M;
            alu_result_w_r <= ALU_ResultM;
            read_data_w_r  <= load_data_s;
            misalign_w_r   <= misalign_s;
         end
         if (FlushW) begin
            reg_write_w_r <= 1'b0;
            misalign_w_r  <= 1'b0;
         end
      end
   end

   assign StallM      = stall_s & ~rst;
   assign RegWriteW   = reg_write_w_r;
   assign ResultSrcW  = result_src_w_r;
   assign RD_W        = rd_w_r;
   assign PCPlus4W    = pc_plus4_w_r;
   assign ALU_ResultW = alu_result_w_r;
   assign ReadDataW   = read_data_w_r;
   assign MisalignW   = misalign_w_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: LOAD_LAT=1 and LOAD_LAT=3 instances share M-stage inputs and a byte-array reference model.
module tb_mem_stage_lsu;
   localparam int XLEN  = 32;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        reg_write_m, mem_write_m, mem_read_m, result_src_m, flush_w;
   logic [2:0]  funct3_m;
   logic [4:0]  rd_m;
   logic [31:0] pc_m, wdata_m, addr_m;

   logic        a_rw, a_rs, a_stall, a_mis;
   logic [4:0]  a_rd;
   logic [31:0] a_pc, a_alu, a_rdat;
   logic        b_rw, b_rs, b_stall, b_mis;
   logic [4:0]  b_rd;
   logic [31:0] b_pc, b_alu, b_rdat;

   mem_stage_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .RegWriteM(reg_write_m), .MemWriteM(mem_write_m), .MemReadM(mem_read_m),
      .ResultSrcM(result_src_m), .Funct3M(funct3_m), .RD_M(rd_m), .PCPlus4M(pc_m), .WriteDataM(wdata_m),
      .ALU_ResultM(addr_m), .FlushW(flush_w), .RegWriteW(a_rw), .ResultSrcW(a_rs), .RD_W(a_rd),
      .PCPlus4W(a_pc), .ALU_ResultW(a_alu), .ReadDataW(a_rdat), .StallM(a_stall), .MisalignW(a_mis));

   mem_stage_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .RegWriteM(reg_write_m), .MemWriteM(mem_write_m), .MemReadM(mem_read_m),
      .ResultSrcM(result_src_m), .Funct3M(funct3_m), .RD_M(rd_m), .PCPlus4M(pc_m), .WriteDataM(wdata_m),
      .ALU_ResultM(addr_m), .FlushW(flush_w), .RegWriteW(b_rw), .ResultSrcW(b_rs), .RD_W(b_rd),
      .PCPlus4W(b_pc), .ALU_ResultW(b_alu), .ReadDataW(b_rdat), .StallM(b_stall), .MisalignW(b_mis));

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  mb [256];
   logic [31:0] prev_alu;
   bit          prev_known;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic bit trap_en();
`ifdef MEM_MISALIGN_TRAP_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit is_mis(input bit mw, input bit mr, input logic [2:0] f3, input logic [31:0] a);
      if (!trap_en()) return 1'b0;
      if (mw) return (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
      if (mr) return ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [7:0]  a, hb, wb, b;
      logic [15:0] h;
      logic [31:0] w;
      a  = addr[7:0];
      hb = {a[7:1], 1'b0};
      wb = {a[7:2], 2'b00};
      b  = mb[a];
      h  = {mb[hb + 8'd1], mb[hb]};
      w  = {mb[wb + 8'd3], mb[wb + 8'd2], mb[wb + 8'd1], mb[wb]};
      case (f3)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd2:    return w;
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      logic [7:0] a, hb, wb;
      a  = addr[7:0];
      hb = {a[7:1], 1'b0};
      wb = {a[7:2], 2'b00};
      case (f3)
         3'd0: mb[a] = wd[7:0];
         3'd1: begin mb[hb] = wd[7:0]; mb[hb + 8'd1] = wd[15:8]; end
         3'd2: begin
            mb[wb] = wd[7:0]; mb[wb + 8'd1] = wd[15:8];
            mb[wb + 8'd2] = wd[23:16]; mb[wb + 8'd3] = wd[31:24];
         end
         default: ;
      endcase
   endtask

   task automatic chk_w(input string tag, input logic rw, input logic mis, input logic rs, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdat,
                        input bit e_rw, input bit e_mis, input bit e_rs, input logic [4:0] e_rd,
                        input logic [31:0] e_pc, input logic [31:0] e_alu, input logic [31:0] e_rdat,
                        input bit full, input bit data);
      chk({tag, "_regwrite"}, 32'(rw), 32'(e_rw));
      chk({tag, "_misalign"}, 32'(mis), 32'(e_mis));
      if (full) begin
         chk({tag, "_resultsrc"}, 32'(rs), 32'(e_rs));
         chk({tag, "_rd"}, 32'(rd), 32'(e_rd));
         chk({tag, "_pc4"}, pc, e_pc);
         chk({tag, "_alu"}, alu, e_alu);
         if (data) chk({tag, "_rdata"}, rdat, e_rdat);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stall_l1"}, 32'(a_stall), 32'd0);
      chk({tag, "_stall_l3"}, 32'(b_stall), 32'd0);
      chk_w({tag, "_l1"}, a_rw, a_mis, a_rs, a_rd, a_pc, a_alu, a_rdat, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      chk_w({tag, "_l3"}, b_rw, b_mis, b_rs, b_rd, b_pc, b_alu, b_rdat, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
   endtask

   task automatic idle();
      reg_write_m = 1'b0; mem_write_m = 1'b0; mem_read_m = 1'b0; result_src_m = 1'b0; flush_w = 1'b0;
      funct3_m = 3'd0; rd_m = 5'd0; pc_m = 32'd0; wdata_m = 32'd0; addr_m = 32'd0;
   endtask

   // One M-stage instruction, entered and left just after a rising edge.
   task automatic op(input bit mw, input bit mr, input bit rw, input bit rs, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                     input logic [31:0] addr, input bit fl, input string tag);
      bit          mis;
      int          n_stall;
      logic [31:0] e_rdat;
      mis     = is_mis(mw, mr, f3, addr);
      n_stall = (mr && !mw && !mis) ? 2 : 0;
      e_rdat  = model_load(f3, addr);
      reg_write_m = rw; mem_write_m = mw; mem_read_m = mr; result_src_m = rs; flush_w = fl;
      funct3_m = f3; rd_m = rd; pc_m = pc; wdata_m = wd; addr_m = addr;
      for (int i = 0; i < n_stall; i++) begin
         #3;
         chk({tag, "_stall_on_l3"}, 32'(b_stall), 32'd1);
         chk({tag, "_stall_l1"}, 32'(a_stall), 32'd0);
         @(posedge clk); #1;
         chk({tag, "_bubble_rw_l3"}, 32'(b_rw), 32'd0);
         chk({tag, "_bubble_mis_l3"}, 32'(b_mis), 32'd0);
         if (prev_known) chk({tag, "_hold_alu_l3"}, b_alu, prev_alu);
      end
      #3;
      chk({tag, "_stall_off_l3"}, 32'(b_stall), 32'd0);
      chk({tag, "_stall_l1"}, 32'(a_stall), 32'd0);
      @(posedge clk); #1;
      if (mw && !mis) model_store(f3, addr, wd);
      chk_w({tag, "_l1"}, a_rw, a_mis, a_rs, a_rd, a_pc, a_alu, a_rdat,
            rw && !fl && !mis, mis && !fl, rs, rd, pc, addr, e_rdat, !fl, !mis);
      chk_w({tag, "_l3"}, b_rw, b_mis, b_rs, b_rd, b_pc, b_alu, b_rdat,
            rw && !fl && !mis, mis && !fl, rs, rd, pc, addr, e_rdat, !fl, !mis);
      prev_known = !fl;
      prev_alu   = addr;
   endtask

   initial begin
      bit          mw, mr, fl;
      logic [2:0]  f3;
      logic [31:0] addr;

      idle();
      mem_read_m = 1'b1;
      prev_known = 1'b1;
      prev_alu   = 32'd0;
      #1 rst = 1'b1;
      #1 chk_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      idle();

      for (int w = 0; w < DEPTH; w++)
         op(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd0, 32'd0, $urandom, 32'(w * 4), 1'b0, "init");

      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd0, 32'h100, 32'hDEADBEEF, 32'h10, 1'b0, "sw10");
      op(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 5'd5, 32'h104, 32'd0, 32'h13, 1'b0, "lb13");
      chk("lb13_const_l1", a_rdat, 32'hFFFFFFDE);
      op(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 5'd6, 32'h108, 32'd0, 32'h13, 1'b0, "lbu13");
      chk("lbu13_const_l1", a_rdat, 32'h000000DE);

      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd0, 32'h10C, 32'h0, 32'h20, 1'b0, "sw20");
      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0, 32'h110, 32'hFFFF1234, 32'h22, 1'b0, "sh22");
      op(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 5'd7, 32'h114, 32'd0, 32'h20, 1'b0, "lw20");
      chk("lw20_const_l1", a_rdat, 32'h12340000);
      op(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 5'd8, 32'h118, 32'd0, 32'h22, 1'b0, "lhu22");
      chk("lhu22_const_l3", b_rdat, 32'h00001234);

      op(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 5'd9, 32'h11C, 32'd0, 32'h10, 1'b0, "lw10");
      chk("lw10_const_l3", b_rdat, 32'hDEADBEEF);
      chk("lw10_rw_l3", 32'(b_rw), 32'd1);

      // reset while the LOAD_LAT=3 instance is mid-load
      reg_write_m = 1'b1; mem_read_m = 1'b1; funct3_m = 3'd2; rd_m = 5'd3; addr_m = 32'h10; pc_m = 32'h120;
      @(posedge clk); #1;
      chk("midload_busy_l3", 32'(b_stall), 32'd1);
      rst = 1'b1;
      #1 chk_zero("midload_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      idle();
      prev_known = 1'b1;
      prev_alu   = 32'd0;
      op(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 5'd3, 32'h124, 32'd0, 32'h10, 1'b0, "lw10_after_rst");
      chk("lw10_after_rst_const_l3", b_rdat, 32'hDEADBEEF);

      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd0, 32'h128, 32'hAAAAAAAA, 32'h11, 1'b0, "sw11_mis");
      chk("sw11_mis_flag_l1", 32'(a_mis), trap_en() ? 32'd1 : 32'd0);
      op(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 5'd4, 32'h12C, 32'd0, 32'h10, 1'b0, "lw10_post_mis");
      chk("lw10_post_mis_const_l1", a_rdat, trap_en() ? 32'hDEADBEEF : 32'hAAAAAAAA);

      op(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 5'd2, 32'h130, 32'h5A5A1234, 32'h30, 1'b1, "sw30_flush");
      op(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 5'd2, 32'h134, 32'd0, 32'h30, 1'b0, "lw30");
      chk("lw30_const_l3", b_rdat, 32'h5A5A1234);

      op(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 5'd1, 32'h138, 32'h0BADF00D, 32'h40, 1'b0, "rdwr40");
      op(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 5'd1, 32'h13C, 32'd0, 32'h1040, 1'b0, "lw40_wrap");
      chk("lw40_wrap_const_l1", a_rdat, 32'h0BADF00D);

      for (int k = 0; k < 300; k++) begin
         mw   = ($urandom % 3) == 0;
         mr   = ($urandom % 2) == 1;
         fl   = ($urandom % 8) == 0;
         f3   = 3'($urandom);
         addr = $urandom;
         if (addr[31:30] != 2'b00) addr = addr & 32'h0000_00FF;
         op(mw, mr, 1'($urandom), 1'($urandom), f3, 5'($urandom), $urandom, $urandom, addr, fl, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
